// File: rtl/fitness_eval.sv
// Sequential fitness harness: sweeps every input vector through a candidate circuit and counts matching output bits against a latched truth table.
// Optional per-vector mismatch map is enabled by defining FITNESS_EVAL_ERR_MAP_EN.
module fitness_eval #(
   parameter int N_IN   = 3,
   parameter int N_OUT  = 2,
   parameter int SETTLE = 2,
   parameter int FW     = 5
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [N_OUT*(2**N_IN)-1:0]  target,
   output logic [N_IN-1:0]             circ_in,
   input  logic [N_OUT-1:0]            circ_out,
   output logic                        busy,
   output logic                        done,
   output logic [FW-1:0]               fitness,
   output logic                        perfect
`ifdef FITNESS_EVAL_ERR_MAP_EN
   ,
   output logic [2**N_IN-1:0]          err_map
`endif
);

   localparam int NVEC = 2**N_IN;
   localparam int TW   = N_OUT*NVEC;
   localparam int SW   = (SETTLE > 0) ? $clog2(SETTLE+1) : 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t            state_reg, state_next;
   logic [N_IN-1:0]   vec_reg,   vec_next;
   logic [SW-1:0]     cnt_reg,   cnt_next;
   logic [FW-1:0]     acc_reg,   acc_next;
   logic [TW-1:0]     tgt_reg,   tgt_next;
   logic [FW-1:0]     fit_reg,   fit_next;
   logic              perf_reg,  perf_next;
   logic              done_reg,  done_next;

   logic [N_OUT-1:0]  tgt_slice;
   logic [N_OUT-1:0]  bit_match;
   logic [FW-1:0]     match_cnt;
   logic [FW-1:0]     sum;
   logic              sample;
   logic              last_vec;

`ifdef FITNESS_EVAL_ERR_MAP_EN
   logic [NVEC-1:0]   errm_reg,  errm_next;
   logic [NVEC-1:0]   emap_reg,  emap_next;
   logic [NVEC-1:0]   errm_upd;
`endif

   assign tgt_slice = tgt_reg[vec_reg*N_OUT +: N_OUT];

   generate
      for (genvar gi = 0; gi < N_OUT; gi++) begin : g_match
         assign bit_match[gi] = (circ_out[gi] == tgt_slice[gi]);
      end
   endgenerate

   always_comb begin
      match_cnt = '0;
      for (int j = 0; j < N_OUT; j++) begin
         match_cnt = match_cnt + FW'(bit_match[j]);
      end
   end

   assign sum      = acc_reg + match_cnt;
   assign sample   = (cnt_reg == SW'(SETTLE));
   assign last_vec = (vec_reg == N_IN'(NVEC-1));

`ifdef FITNESS_EVAL_ERR_MAP_EN
   assign errm_upd = errm_reg | (NVEC'(~&bit_match) << vec_reg);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         vec_reg   <= '0;
         cnt_reg   <= '0;
         acc_reg   <= '0;
         tgt_reg   <= '0;
         fit_reg   <= '0;
         perf_reg  <= 1'b0;
         done_reg  <= 1'b0;
`ifdef FITNESS_EVAL_ERR_MAP_EN
         errm_reg  <= '0;
         emap_reg  <= '0;
`endif
      end else begin
         state_reg <= state_next;
         vec_reg   <= vec_next;
         cnt_reg   <= cnt_next;
         acc_reg   <= acc_next;
         tgt_reg   <= tgt_next;
         fit_reg   <= fit_next;
         perf_reg  <= perf_next;
         done_reg  <= done_next;
`ifdef FITNESS_EVAL_ERR_MAP_EN
         errm_reg  <= errm_next;
         emap_reg  <= emap_next;
`endif
      end
   end

   always_comb begin
      state_next = state_reg;
      vec_next   = vec_reg;
      cnt_next   = cnt_reg;
      acc_next   = acc_reg;
      tgt_next   = tgt_reg;
      fit_next   = fit_reg;
      perf_next  = perf_reg;
      done_next  = 1'b0;
`ifdef FITNESS_EVAL_ERR_MAP_EN
      errm_next  = errm_reg;
      emap_next  = emap_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (start) begin
               tgt_next   = target;
               acc_next   = '0;
               vec_next   = '0;
               cnt_next   = '0;
               state_next = RUN;
`ifdef FITNESS_EVAL_ERR_MAP_EN
               errm_next  = '0;
`endif
            end
         end
         RUN: begin
            if (sample) begin
               cnt_next = '0;
               acc_next = sum;
               // Wraps to 0 after the last vector, leaving circ_in idle at 0.
               vec_next = vec_reg + N_IN'(1);
`ifdef FITNESS_EVAL_ERR_MAP_EN
               errm_next = errm_upd;
`endif
               if (last_vec) begin
                  fit_next   = sum;
                  perf_next  = (sum == FW'(TW));
                  done_next  = 1'b1;
                  state_next = IDLE;
`ifdef FITNESS_EVAL_ERR_MAP_EN
                  emap_next  = errm_upd;
`endif
               end
            end else begin
               cnt_next = cnt_reg + SW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign circ_in = vec_reg;
   assign busy    = (state_reg == RUN);
   assign done    = done_reg;
   assign fitness = fit_reg;
   assign perfect = perf_reg;
`ifdef FITNESS_EVAL_ERR_MAP_EN
   assign err_map = emap_reg;
`endif

endmodule
